reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural register file behind the operand read stage.
- Answers the read stage's two register read requests (`reg_a_read`/`reg_a`, `reg_b_read`/`reg_b`) with `reg_a_value`/`reg_b_value`.
- Accepts the writeback stage's result bus (`wb_en`/`wb_dst_reg`/`wb_out`).
- Read data is registered (1-cycle latency), with same-edge write-to-read bypass and an optional hardwired zero register.

Parameters:
- NUM_REGS, 16, number of architectural registers; index width is clog2(NUM_REGS) = 4.
- DATA_W, 16, register width in bits.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- cpu_clk  input  1  clock; all state updates on the rising edge.
- cpu_rst  input  1  synchronous, active-high reset.
- reg_a_read  input  1  read request, port A.
- reg_a  input  4  register index, port A.
- reg_b_read  input  1  read request, port B.
- reg_b  input  4  register index, port B.
- wb_en  input  1  write enable from writeback.
- wb_dst_reg  input  4  write index.
- wb_out  input  16  write data.
- reg_a_value  output  16  port A read data, valid the cycle after the request.
- reg_b_value  output  16  port B read data, valid the cycle after the request.
- reg_a_valid  output  1  high for exactly one cycle when reg_a_value carries new data.
- reg_b_valid  output  1  high for exactly one cycle when reg_b_value carries new data.
- dbg_reg  input  4  debug/bench peek index.
- dbg_value  output  16  combinational contents of array[dbg_reg]; post-write contents, no bypass.

Behaviour:
- Reset (cpu_rst high at an edge):
  - All NUM_REGS entries cleared to 0.
  - reg_a_value, reg_b_value = 0; reg_a_valid, reg_b_valid = 0.
  - A write presented in the reset cycle is discarded.
  - Reset wins over any simultaneous read or write, including reset asserted mid-sequence.
- Write: at an edge with wb_en = 1 and no reset, array[wb_dst_reg] <= wb_out.
  - When ZERO_REG = 1 and wb_dst_reg = 0, the write is dropped.
- Read, port X in {a, b}: at an edge with reg_X_read = 1:
  - reg_X_value <= array[reg_X], and reg_X_valid <= 1.
  - With reg_X_read = 0: reg_X_value holds its previous value and reg_X_valid <= 0.
- Bypass: when a read and a write target the same index at the same edge, the read returns wb_out (new data), never the old contents.
  - Applies independently to both ports.
  - Does not apply to index 0 when ZERO_REG = 1; that read returns 0.
- Both ports may read the same index in the same cycle; both return identical data.
- Latency: request in cycle N, data and valid visible in cycle N+1.
  - Back-to-back requests give one result per cycle, with no bubbles and no stall output.
- Indices are always in range: NUM_REGS equals 2^index width, so no out-of-range handling is required.
- dbg_value is purely combinational from the array; it does not affect any state.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_IDX_W = 4, DATA_W = 16, NUM_REGS = 16;
  - typedef reg_idx_t = logic [3:0];
  - typedef word_t = logic [15:0].
- The read stage and the writeback stage use the same package.
- One sub-module, reg_file_rd_port: one registered read port with bypass compare. It is instantiated twice, for A and B.
- The storage array and write logic live in reg_file.

Test Plan:
- Reset: write 0xBEEF to r5; assert cpu_rst one cycle; read r5 -> reg_a_value = 0x0000, reg_a_valid = 1 one cycle after the request; dbg_value(r5) = 0.
- Basic write/read: wb_en = 1, r3 <= 0x1234, r7 <= 0xABCD on consecutive edges; read r3 on A and r7 on B in the same cycle -> next cycle A = 0x1234, B = 0xABCD, both valids = 1, then both valids drop to 0 with values held.
- Bypass: r9 holds 0x0001; in one cycle write r9 <= 0x5555 and read r9 on A and B -> next cycle both = 0x5555; dbg_value(r9) = 0x5555.
- Zero register (ZERO_REG = 1): write r0 <= 0xFFFF while reading r0 -> returns 0x0000; next read returns 0x0000. With ZERO_REG = 0 the same sequence returns 0xFFFF both times.
- Back-to-back streaming: preload r1..r15 with values 0x1000 + i; read r1..r15 on A over 15 consecutive cycles -> 15 consecutive valid cycles, each returning 0x1000 + i, no gaps.
- Reset mid-operation: read request on A and write r4 <= 0x7777 in the same cycle as cpu_rst = 1 -> next cycle reg_a_valid = 0, reg_a_value = 0, and r4 reads back 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared operand types for the read, register file and writeback stages.
package cpu_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: picks array data or the same-edge writeback data,
// with register 0 forced to zero when the hardwired zero register is enabled.
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic     cpu_clk,
  input  logic     cpu_rst,
  input  logic     rd_en,
  input  reg_idx_t rd_idx,
  input  word_t    arr_data,
  input  logic     wr_en,
  input  reg_idx_t wr_idx,
  input  word_t    wr_data,
  output word_t    rd_value,
  output logic     rd_valid
);

  word_t value_d, value_q;
  logic  valid_d, valid_q;

  // Next read value: hold when idle, otherwise zero-reg / bypass / array.
  always_comb begin
    value_d = value_q;
    valid_d = 1'b0;
    if (rd_en) begin
      valid_d = 1'b1;
      if (ZERO_REG && (rd_idx == '0)) begin
        value_d = '0;
      end else if (wr_en && (wr_idx == rd_idx)) begin
        value_d = wr_data;
      end else begin
        value_d = arr_data;
      end
    end
  end

  // Read result registers; reset overrides any pending request.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign rd_value = value_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: one writeback port, two registered read ports
// with same-edge write bypass, and a combinational debug peek.
module reg_file
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic     cpu_clk,
  input  logic     cpu_rst,
  input  logic     reg_a_read,
  input  reg_idx_t reg_a,
  input  logic     reg_b_read,
  input  reg_idx_t reg_b,
  input  logic     wb_en,
  input  reg_idx_t wb_dst_reg,
  input  word_t    wb_out,
  output word_t    reg_a_value,
  output word_t    reg_b_value,
  output logic     reg_a_valid,
  output logic     reg_b_valid,
  input  reg_idx_t dbg_reg,
  output word_t    dbg_value
);

  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_ok;

  // Writes to register 0 are dropped when it is the hardwired zero register.
  always_comb begin
    wr_ok = wb_en && !(ZERO_REG && (wb_dst_reg == '0));
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wb_dst_reg] = wb_out;
    end
  end

  // Storage array; reset clears every entry and discards a same-cycle write.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign dbg_value = mem_q[dbg_reg];

  reg_file_rd_port #(.ZERO_REG(ZERO_REG)) u_rd_a (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .rd_en    (reg_a_read),
    .rd_idx   (reg_a),
    .arr_data (mem_q[reg_a]),
    .wr_en    (wb_en),
    .wr_idx   (wb_dst_reg),
    .wr_data  (wb_out),
    .rd_value (reg_a_value),
    .rd_valid (reg_a_valid)
  );

  reg_file_rd_port #(.ZERO_REG(ZERO_REG)) u_rd_b (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .rd_en    (reg_b_read),
    .rd_idx   (reg_b),
    .arr_data (mem_q[reg_b]),
    .wr_en    (wb_en),
    .wr_idx   (wb_dst_reg),
    .wr_data  (wb_out),
    .rd_value (reg_b_value),
    .rd_valid (reg_b_valid)
  );

endmodule
